uc_sequencer: RTL and testbench
===============================

# uc_sequencer

Microprogram sequencer for the CPU control unit. Owns the microcode ROM address, computing each next micro-address from the sequencing field of the current microword, the ALU flags and the instruction decoder's dispatch address. Holds a small return stack for micro-subroutines and flags microwords as valid for execution by the datapath. It sits between the 256x16 microcode ROM (address sampled and data updated on negedge clk) and the decoder/datapath.

## Interface
- ADDR_WIDTH, 8, micro-address width; equals the ROM address width
- DATA_WIDTH, 16, microword width
- STACK_DEPTH, 4, return-stack entries (power of two)
- clk  in  1  system clock; sequencer registers update on posedge
- rst_n  in  1  reset, asynchronous, active-low
- uc_word  in  DATA_WIDTH  microword from ROM, valid from negedge to next negedge
- flags  in  4  {V,C,N,Z} from ALU, sampled at posedge
- irq_pend  in  1  interrupt pending
- stall  in  1  freeze sequencer (memory wait)
- disp_valid  in  1  decoder has a dispatch address ready
- disp_addr  in  ADDR_WIDTH  decoder opcode entry point
- adr_p  out  ADDR_WIDTH  ROM address (registered micro-PC)
- uc_valid  out  1  current microword is to be executed this cycle
- disp_ack  out  1  dispatch address consumed this posedge
- halted  out  1  sequencer halted
- stack_err  out  1  sticky over/underflow flag

## Operation
- Microword fields: op = uc_word[15:13], cond = uc_word[12:10], target = uc_word[7:0]. Bits [9:8] and, for non-branch ops, [7:0] belong to the datapath.
- cond: 0 always, 1 Z, 2 N, 3 C, 4 V, 5 !Z, 6 !C, 7 irq_pend.
- op: 0 NEXT adr+1; 1 JMP cond ? target : adr+1; 2 CALL cond ? (push adr+1, target) : adr+1; 3 RET cond ? pop : adr+1; 4 DISP disp_valid ? disp_addr : hold; 5 WAIT cond ? adr+1 : hold; 6 RST goto 0; 7 HALT.
- States: FILL, RUN, HALT. FILL is entered on reset; after one posedge, go to RUN with adr_p unchanged (0). RUN applies the op table. HALT is entered on op 7 or on stack error. Only rst_n leaves HALT.
- exec = RUN & !stall & !(op==DISP & !disp_valid) & !(op==WAIT & !cond_true). uc_valid = exec. The micro-PC advances only when exec, or on a held DISP/WAIT (adr_p unchanged).
- disp_ack = RUN & !stall & op==DISP & disp_valid. It is combinational and lasts one cycle.
- adr+1 wraps 255 -> 0 with no error.
- CALL with stack full: set stack_err, go to HALT, no push, uc_valid still 1 that cycle. RET with stack empty: same behaviour. A CALL/RET whose condition is false never errors.
- stall has priority over every op: no state, stack or adr change, uc_valid=0, disp_ack=0.

## Timing
- Reset values: adr_p=0, state FILL, stack pointer 0, uc_valid=0, disp_ack=0, halted=0, stack_err=0. Stack contents are not reset.
- adr_p changes at posedge and is stable at the following negedge, where the ROM samples it. uc_word for adr_p is valid at the next posedge, giving 1-cycle branch latency with no delay slot.
- First execution after rst_n deasserts is at the second posedge (FILL consumes one).
- halted asserts the cycle after the HALT or error word executes.
- Asserting rst_n low mid-operation clears state immediately, independent of clk.

## Structure
- Package uc_pkg: op and cond encodings, field bit positions, state enum, ADDR_WIDTH/DATA_WIDTH defaults. The microassembler uses the same values.
- Sub-module uc_stack: LIFO with push/pop/full/empty, depth STACK_DEPTH, width ADDR_WIDTH.
- Top: condition mux, next-address mux, state register, disp_ack/uc_valid logic.

## Test plan
- Reset then NEXT words at 0..2 -> adr_p 0,0,1,2; uc_valid 0 in FILL then 1. Word at 255 is NEXT -> adr_p wraps to 0.
- JMP cond=Z target 0x40 with Z=1 -> adr_p=0x40. Same word with Z=0 -> adr_p+1.
- CALL 0x80 at 0x10, RET at 0x80 -> adr_p 0x80 then 0x11. Five nested CALLs -> stack_err=1 and halted=1 after the 5th.
- DISP with disp_valid low for 3 cycles then disp_addr=0x9C -> adr_p held, uc_valid 0 for 3 cycles, then one disp_ack pulse and adr_p=0x9C.
- stall high for 2 cycles during a CALL word -> no push, adr_p held, uc_valid 0. After release, the CALL executes once.
- rst_n pulsed low mid-WAIT at adr 0x33 -> adr_p=0 immediately, FILL, stack_err cleared.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the microprogram sequencer and the microassembler:
// microword field positions, op/cond codes, FSM state constants.
package uc_pkg;

    localparam int UC_ADDR_WIDTH = 8;
    localparam int UC_DATA_WIDTH = 16;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int COND_MSB = 12;
    localparam int COND_LSB = 10;
    localparam int TGT_LSB  = 0;

    localparam logic [2:0] OP_NEXT = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_DISP = 3'd4;
    localparam logic [2:0] OP_WAIT = 3'd5;
    localparam logic [2:0] OP_RST  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_N      = 3'd2;
    localparam logic [2:0] COND_C      = 3'd3;
    localparam logic [2:0] COND_V      = 3'd4;
    localparam logic [2:0] COND_NZ     = 3'd5;
    localparam logic [2:0] COND_NC     = 3'd6;
    localparam logic [2:0] COND_IRQ    = 3'd7;

    // ALU flag vector is {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/uc_sequencer_if.sv
// Sequencer bus: ROM address/data plus the decoder dispatch handshake.
interface uc_sequencer_if #(
    parameter int ADDR_WIDTH = uc_pkg::UC_ADDR_WIDTH,
    parameter int DATA_WIDTH = uc_pkg::UC_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] adr_p;
    logic [DATA_WIDTH-1:0] uc_word;
    logic                  disp_valid;
    logic [ADDR_WIDTH-1:0] disp_addr;
    logic                  disp_ack;

    modport master (
        output adr_p,
        output disp_ack,
        input  uc_word,
        input  disp_valid,
        input  disp_addr
    );

    modport slave (
        input  adr_p,
        input  disp_ack,
        output uc_word,
        output disp_valid,
        output disp_addr
    );
endinterface

// File: rtl/uc_stack.sv
// Micro-subroutine return stack: LIFO with combinational top-of-stack read.
module uc_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      sp;
    logic [PW-1:0]    top_idx;

    assign top_idx = sp[PW-1:0] - PW'(1);
    assign dout    = mem[top_idx];
    assign full    = (sp == (PW+1)'(DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + (PW+1)'(1);
        end else if (pop) begin
            sp <= sp - (PW+1)'(1);
        end
    end

    // Contents are deliberately left unreset; only the pointer matters.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp[PW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/uc_sequencer.sv
// Microprogram sequencer: computes the next micro-address from the current
// microword, ALU flags and decoder dispatch, with a small return stack.
module uc_sequencer
    import uc_pkg::*;
#(
    parameter int ADDR_WIDTH  = UC_ADDR_WIDTH,
    parameter int DATA_WIDTH  = UC_DATA_WIDTH,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uc_sequencer_if.master        bus,
    input  logic [3:0]            flags,
    input  logic                  irq_pend,
    input  logic                  stall,
    output logic                  uc_valid,
    output logic                  halted,
    output logic                  stack_err
);
    logic [DATA_WIDTH-1:0] word;
    logic [2:0]            op;
    logic [2:0]            cond;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] adr_inc;
    logic [ADDR_WIDTH-1:0] adr_nxt;
    logic [ADDR_WIDTH-1:0] pop_data;
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  cond_true;
    logic                  active;
    logic                  exec;
    logic                  err;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  unused_dp_bits;

    assign word    = bus.uc_word;
    assign op      = word[OP_MSB:OP_LSB];
    assign cond    = word[COND_MSB:COND_LSB];
    assign target  = word[TGT_LSB +: ADDR_WIDTH];
    assign adr_inc = bus.adr_p + ADDR_WIDTH'(1);

    // Bits between target and cond are datapath-owned
    assign unused_dp_bits = ^word[COND_LSB-1:TGT_LSB+ADDR_WIDTH];

    always_comb begin
        case (cond)
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = flags[FLAG_Z];
            COND_N:      cond_true = flags[FLAG_N];
            COND_C:      cond_true = flags[FLAG_C];
            COND_V:      cond_true = flags[FLAG_V];
            COND_NZ:     cond_true = !flags[FLAG_Z];
            COND_NC:     cond_true = !flags[FLAG_C];
            default:     cond_true = irq_pend;
        endcase
    end

    assign active = (state == ST_RUN) && !stall;
    assign exec   = active
                  && !((op == OP_DISP) && !bus.disp_valid)
                  && !((op == OP_WAIT) && !cond_true);

    assign uc_valid     = exec;
    assign bus.disp_ack = active && (op == OP_DISP) && bus.disp_valid;
    assign halted       = (state == ST_HALT);

    assign push = exec && cond_true && (op == OP_CALL) && !full;
    assign pop  = exec && cond_true && (op == OP_RET) && !empty;
    assign err  = exec && cond_true
                && (((op == OP_CALL) && full) || ((op == OP_RET) && empty));

    uc_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (adr_inc),
        .dout  (pop_data),
        .full  (full),
        .empty (empty)
    );

    // Held DISP/WAIT and stack errors leave the micro-PC where it is.
    always_comb begin
        adr_nxt   = bus.adr_p;
        state_nxt = state;
        case (state)
            ST_FILL: state_nxt = ST_RUN;
            ST_RUN: begin
                if (exec) begin
                    case (op)
                        OP_NEXT, OP_WAIT: adr_nxt = adr_inc;
                        OP_JMP:  adr_nxt = cond_true ? target : adr_inc;
                        OP_CALL: begin
                            if (!cond_true)  adr_nxt = adr_inc;
                            else if (!full)  adr_nxt = target;
                        end
                        OP_RET: begin
                            if (!cond_true)  adr_nxt = adr_inc;
                            else if (!empty) adr_nxt = pop_data;
                        end
                        OP_DISP: adr_nxt = bus.disp_addr;
                        OP_RST:  adr_nxt = '0;
                        default: adr_nxt = bus.adr_p;
                    endcase
                    if (err || (op == OP_HALT)) state_nxt = ST_HALT;
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            bus.adr_p <= '0;
            stack_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus.adr_p <= adr_nxt;
            if (err) stack_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uc_sequencer.sv
// Directed and randomized checks of uc_sequencer against a queue-based
// behavioural model of the micro-sequencing rules.
module tb_uc_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] flags = 4'h0;
    logic       irq_pend = 1'b0;
    logic       stall = 1'b0;
    logic       uc_valid;
    logic       halted;
    logic       stack_err;

    uc_sequencer_if bus ();

    uc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flags     (flags),
        .irq_pend  (irq_pend),
        .stall     (stall),
        .uc_valid  (uc_valid),
        .halted    (halted),
        .stack_err (stack_err)
    );

    logic [15:0] rom [256];
    int n_pass = 0;
    int n_chk  = 0;

    // Model: 0 = fill, 1 = run, 2 = halted
    int  m_state;
    int  m_pc;
    int  m_stk[$];
    bit  m_err;
    bit  exp_valid;
    bit  exp_ack;

    always #5 clk = ~clk;

    // ROM: samples address and presents data on the falling edge
    always @(negedge clk) bus.uc_word <= rom[bus.adr_p];

    function automatic logic [15:0] mw(int op, int cond, int tgt);
        return {3'(op), 3'(cond), 2'b00, 8'(tgt)};
    endfunction

    function automatic bit cond_ok(int c);
        case (c)
            0: return 1'b1;
            1: return flags[0];
            2: return flags[1];
            3: return flags[2];
            4: return flags[3];
            5: return !flags[0];
            6: return !flags[2];
            default: return irq_pend;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at posedge+1; asserts reset and checks outputs before any edge.
    task automatic do_reset();
        rst_n = 1'b0;
        m_state = 0;
        m_pc = 0;
        m_stk.delete();
        m_err = 1'b0;
        #1;
        chk("rst_adr_p", bus.adr_p, 0);
        chk("rst_uc_valid", uc_valid, 0);
        chk("rst_disp_ack", bus.disp_ack, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stack_err", stack_err, 0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic model_cycle();
        logic [15:0] w;
        int op;
        bit c;
        int tgt;
        int inc;
        w = rom[m_pc];
        op = int'(w[15:13]);
        c = cond_ok(int'(w[12:10]));
        tgt = int'(w[7:0]);
        inc = (m_pc + 1) % 256;
        exp_valid = 1'b0;
        exp_ack = 1'b0;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1 && !stall) begin
            exp_ack = (op == 4) && bus.disp_valid;
            if (!((op == 4 && !bus.disp_valid) || (op == 5 && !c))) begin
                exp_valid = 1'b1;
                case (op)
                    0, 5: m_pc = inc;
                    1: m_pc = c ? tgt : inc;
                    2: begin
                        if (!c) m_pc = inc;
                        else if (m_stk.size() == DEPTH) begin m_err = 1'b1; m_state = 2; end
                        else begin m_stk.push_back(inc); m_pc = tgt; end
                    end
                    3: begin
                        if (!c) m_pc = inc;
                        else if (m_stk.size() == 0) begin m_err = 1'b1; m_state = 2; end
                        else m_pc = m_stk.pop_back();
                    end
                    4: m_pc = int'(bus.disp_addr);
                    6: m_pc = 0;
                    default: m_state = 2;
                endcase
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        model_cycle();
        chk("uc_valid", uc_valid, exp_valid);
        chk("disp_ack", bus.disp_ack, exp_ack);
        @(posedge clk);
        #1;
        chk("adr_p", bus.adr_p, m_pc);
        chk("halted", halted, m_state == 2);
        chk("stack_err", stack_err, m_err);
    endtask

    initial begin
        bus.disp_valid = 1'b0;
        bus.disp_addr  = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        @(posedge clk);
        #1;

        // Straight-line NEXT words, then wrap from 255
        do_reset();
        repeat (3) step();
        rom[3] = mw(1, 0, 255);
        repeat (3) step();
        chk("wrap_to_zero", bus.adr_p, 0);

        // Conditional jump on Z, taken and not taken
        rom[0] = mw(1, 1, 8'h40);
        flags = 4'($urandom) | 4'h1;
        do_reset();
        repeat (2) step();
        chk("jmp_z_taken", bus.adr_p, 8'h40);
        flags = 4'($urandom) & 4'hE;
        do_reset();
        repeat (2) step();
        chk("jmp_z_not_taken", bus.adr_p, 8'h01);

        // CALL / RET round trip
        rom[0] = mw(1, 0, 8'h10);
        rom[8'h10] = mw(2, 0, 8'h80);
        rom[8'h80] = mw(3, 0, 0);
        rom[8'h11] = 16'h0000;
        do_reset();
        repeat (3) step();
        chk("call_target", bus.adr_p, 8'h80);
        step();
        chk("ret_addr", bus.adr_p, 8'h11);

        // Five nested calls overflow a four-deep stack
        for (int i = 0; i < 5; i++) rom[i] = mw(2, 0, i + 1);
        do_reset();
        repeat (6) step();
        chk("overflow_err", stack_err, 1);
        chk("overflow_halt", halted, 1);
        repeat (2) step();

        // RET on empty stack errors; false-condition RET does not
        rom[0] = mw(3, 0, 0);
        do_reset();
        repeat (3) step();
        rom[0] = mw(3, 1, 0);
        flags = 4'h0;
        do_reset();
        repeat (2) step();

        // Dispatch held three cycles, then consumed
        rom[0] = mw(4, 0, 0);
        rom[8'h9C] = 16'h0000;
        bus.disp_valid = 1'b0;
        bus.disp_addr = 8'($urandom);
        do_reset();
        repeat (4) step();
        bus.disp_valid = 1'b1;
        bus.disp_addr = 8'h9C;
        step();
        chk("disp_target", bus.adr_p, 8'h9C);
        bus.disp_valid = 1'b0;
        step();

        // Stall over a CALL: single push after release
        rom[0] = mw(2, 0, 8'h80);
        rom[8'h80] = mw(3, 0, 0);
        rom[1] = mw(3, 0, 0);
        do_reset();
        step();
        stall = 1'b1;
        repeat (2) step();
        stall = 1'b0;
        repeat (4) step();

        // Async reset in the middle of a WAIT with a live stack entry
        rom[0] = mw(2, 0, 8'h33);
        rom[8'h33] = mw(5, 7, 0);
        rom[8'h34] = mw(3, 0, 0);
        irq_pend = 1'b0;
        do_reset();
        repeat (4) step();
        do_reset();
        repeat (2) step();
        irq_pend = 1'b1;
        repeat (4) step();
        chk("sp_cleared_err", stack_err, 1);

        // Random programs and inputs
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($urandom);
            if (rom[i][15:13] == 3'd7 && $urandom_range(3) != 0) rom[i][15:13] = 3'd0;
        end
        do_reset();
        for (int n = 0; n < 400; n++) begin
            flags = 4'($urandom);
            irq_pend = 1'($urandom_range(1));
            stall = ($urandom_range(7) == 0);
            bus.disp_valid = 1'($urandom_range(1));
            bus.disp_addr = 8'($urandom);
            step();
            if (m_state == 2 && $urandom_range(3) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
